// File: rtl/rx_pkg.sv
// Shared types and constants for the UART receive controller: FSM encoding,
// entry field widths and the bit-time table that drives the engine.
package rx_pkg;

  localparam int DATA_W  = 8;
  localparam int STAT_W  = 3;
  localparam int ENTRY_W = DATA_W + STAT_W;
  localparam int MAX_W   = 19;
  localparam int BAUD_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CAPT = 2'b01,
    ACK  = 2'b10,
    WCLR = 2'b11
  } rx_state_t;

  // 100 MHz divided by the line rate, rounded to nearest
  localparam logic [MAX_W-1:0] BAUD_300    = 19'd333333;
  localparam logic [MAX_W-1:0] BAUD_1200   = 19'd83333;
  localparam logic [MAX_W-1:0] BAUD_2400   = 19'd41667;
  localparam logic [MAX_W-1:0] BAUD_4800   = 19'd20833;
  localparam logic [MAX_W-1:0] BAUD_9600   = 19'd10417;
  localparam logic [MAX_W-1:0] BAUD_19200  = 19'd5208;
  localparam logic [MAX_W-1:0] BAUD_38400  = 19'd2604;
  localparam logic [MAX_W-1:0] BAUD_57600  = 19'd1736;
  localparam logic [MAX_W-1:0] BAUD_115200 = 19'd868;
  localparam logic [MAX_W-1:0] BAUD_230400 = 19'd434;
  localparam logic [MAX_W-1:0] BAUD_460800 = 19'd217;
  localparam logic [MAX_W-1:0] BAUD_921600 = 19'd109;

  localparam logic [BAUD_W-1:0] BAUD_IDX_DEFAULT = 4'd4;

  function automatic logic [MAX_W-1:0] baud_max(input logic [BAUD_W-1:0] idx);
    logic [MAX_W-1:0] m;
    case (idx)
      4'd0:    m = BAUD_300;
      4'd1:    m = BAUD_1200;
      4'd2:    m = BAUD_2400;
      4'd3:    m = BAUD_4800;
      4'd4:    m = BAUD_9600;
      4'd5:    m = BAUD_19200;
      4'd6:    m = BAUD_38400;
      4'd7:    m = BAUD_57600;
      4'd8:    m = BAUD_115200;
      4'd9:    m = BAUD_230400;
      4'd10:   m = BAUD_460800;
      4'd11:   m = BAUD_921600;
      default: m = BAUD_115200;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through circular FIFO holding {status, data} receive entries.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module rx_fifo
  import rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic [ADDR_W:0]    count,
  output logic               full,
  output logic               empty
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage is data only and is never reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/rx_ctrl.sv
// UART receive controller: engine configuration, one-capture-per-frame
// handshake with the engine, and the processor-side FIFO with irq/lost flags.
module rx_ctrl
  import rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [BAUD_W-1:0] cfg_baud,
  input  logic              cfg_eight,
  input  logic              cfg_pen,
  input  logic              cfg_ohel,
  output logic [MAX_W-1:0]  rx_max,
  output logic              rx_eight,
  output logic              rx_pen,
  output logic              rx_ohel,
  input  logic              rx_rdy,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [STAT_W-1:0] rx_status,
  output logic              rx_read,
  input  logic              cpu_pop,
  output logic [DATA_W-1:0] cpu_data,
  output logic [STAT_W-1:0] cpu_status,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_count,
  input  logic              irq_en,
  output logic              irq,
  output logic              lost,
  input  logic              clr_lost
);

  rx_state_t          state;
  rx_state_t          state_nxt;
  logic               capt;
  logic               accept;
  logic               push;
  logic [ENTRY_W-1:0] head;

  // Configuration register; the bit-time count is looked up at write time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_max   <= BAUD_9600;
      rx_eight <= 1'b1;
      rx_pen   <= 1'b0;
      rx_ohel  <= 1'b0;
    end else if (cfg_we) begin
      rx_max   <= baud_max(cfg_baud);
      rx_eight <= cfg_eight;
      rx_pen   <= cfg_pen;
      rx_ohel  <= cfg_ohel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // WCLR waits for RXRDY to fall so a frame is never captured twice
  always_comb begin
    state_nxt = state;
    capt      = 1'b0;
    rx_read   = 1'b0;
    case (state)
      IDLE: if (rx_rdy) state_nxt = CAPT;
      CAPT: begin
        capt      = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        rx_read   = 1'b1;
        state_nxt = WCLR;
      end
      WCLR: if (!rx_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A full FIFO still takes the frame when the processor pops in the same cycle
  assign accept = ~fifo_full | cpu_pop;
  assign push   = capt & accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost <= 1'b0;
      irq  <= 1'b0;
    end else begin
      if (capt && !accept) lost <= 1'b1;
      else if (clr_lost)   lost <= 1'b0;
      irq <= irq_en & ~fifo_empty;
    end
  end

  rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data({rx_status, rx_data}),
    .pop      (cpu_pop),
    .head     (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign cpu_data   = head[DATA_W-1:0];
  assign cpu_status = head[ENTRY_W-1:DATA_W];

endmodule
